// File: rtl/fp_arb_pkg.sv
// rtl/fp_arb_pkg.sv - shared tag type and FP constants for the FP operator arbiter
package fp_arb_pkg;

    // Tags are sized for the largest supported requester count so every build shares one type
    localparam int MAX_NUM_REQ = 8;
    localparam int TAG_W       = $clog2(MAX_NUM_REQ);

    typedef logic [TAG_W-1:0] tag_t;

    localparam logic [31:0] FP_ZERO = 32'h00000000;
    localparam logic [31:0] FP_ONE  = 32'h3f800000;

endpackage

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - in-order FIFO of requester tags for outstanding core operations
module tag_fifo
    import fp_arb_pkg::*;
#(
    parameter int WIDTH = TAG_W,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Storage needs no reset: only entries below count are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; depth is a power of two so pointers wrap naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_op_arbiter.sv
// rtl/fp_op_arbiter.sv - shares one pipelined FP core among requesters; FP_ARB_FIXED_PRIO_EN selects fixed priority
module fp_op_arbiter
    import fp_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_OUT = 16,
    parameter int DATA_W  = 32
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [NUM_REQ-1:0]          req_valid_in,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a_in,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b_in,
    output logic [NUM_REQ-1:0]          req_ready_out,
    output logic [DATA_W-1:0]           core_a_out,
    output logic [DATA_W-1:0]           core_b_out,
    output logic                        core_valid_out,
    input  logic [DATA_W-1:0]           core_result_in,
    input  logic                        core_valid_in,
    output logic [NUM_REQ-1:0]          resp_valid_out,
    output logic [DATA_W-1:0]           resp_data_out,
    output logic                        busy_out,
    output logic                        err_out
);
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    logic               grant_any;
    tag_t               grant_idx;
    logic               accept;
    logic [DATA_W-1:0]  sel_a;
    logic [DATA_W-1:0]  sel_b;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic               pop;
    tag_t               head_tag;
    logic [NUM_REQ-1:0] head_onehot;

`ifdef FP_ARB_FIXED_PRIO_EN
    // Lowest valid index wins; no history is kept
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_in[i]) begin
                grant_any = 1'b1;
                grant_idx = tag_t'(i);
            end
        end
    end
`else
    tag_t ptr;

    // Round-robin: search indices above the last winner first, then wrap to 0..ptr
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid_in[i] && (i > int'(ptr))) begin
                grant_any = 1'b1;
                grant_idx = tag_t'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_any && req_valid_in[i] && (i <= int'(ptr))) begin
                grant_any = 1'b1;
                grant_idx = tag_t'(i);
            end
        end
    end

    // Pointer moves to the winner only when the grant is actually taken
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ptr <= tag_t'(NUM_REQ - 1);
        end else if (accept) begin
            ptr <= grant_idx;
        end
    end
`endif

    // One-hot ready; a full tag FIFO blocks even when a pop lands in the same cycle
    always_comb begin
        accept        = grant_any && !fifo_full && !rst_in;
        req_ready_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_out[i] = accept && (grant_idx == tag_t'(i));
        end
    end

    // Operand mux for the granted requester
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == tag_t'(i)) begin
                sel_a = req_a_in[i*DATA_W +: DATA_W];
                sel_b = req_b_in[i*DATA_W +: DATA_W];
            end
        end
    end

    // Decode the oldest outstanding tag into a per-requester strobe
    always_comb begin
        head_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            head_onehot[i] = (head_tag == tag_t'(i));
        end
    end

    assign pop      = core_valid_in && !fifo_empty;
    assign busy_out = (fifo_count != '0);

    tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (accept),
        .push_data (grant_idx),
        .pop       (pop),
        .pop_data  (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Issue register: one core beat per accepted request, the cycle after accept
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            core_valid_out <= 1'b0;
            core_a_out     <= '0;
            core_b_out     <= '0;
        end else begin
            core_valid_out <= accept;
            if (accept) begin
                core_a_out <= sel_a;
                core_b_out <= sel_b;
            end
        end
    end

    // Return register: route each core result to the tag at the FIFO head; orphans raise err
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            resp_valid_out <= '0;
            resp_data_out  <= '0;
            err_out        <= 1'b0;
        end else begin
            resp_valid_out <= pop ? head_onehot : '0;
            if (pop) begin
                resp_data_out <= core_result_in;
            end
            if (core_valid_in && fifo_empty) begin
                err_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp_op_arbiter.sv
// tb/tb_fp_op_arbiter.sv - scoreboard bench for fp_op_arbiter with a fixed-latency adder model
module tb_fp_op_arbiter;
    import fp_arb_pkg::*;

    localparam int N    = 4;
    localparam int MAXO = 16;
    localparam int DW   = 32;
    localparam int LAT  = 11;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_a = '0;
    logic [N*DW-1:0] req_b = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   core_a;
    logic [DW-1:0]   core_b;
    logic            core_valid_o;
    logic [DW-1:0]   core_result = '0;
    logic            core_valid_i = 1'b0;
    logic [N-1:0]    resp_valid;
    logic [DW-1:0]   resp_data;
    logic            busy;
    logic            err;

    fp_op_arbiter #(.NUM_REQ(N), .MAX_OUT(MAXO), .DATA_W(DW)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_valid_in   (req_valid),
        .req_a_in       (req_a),
        .req_b_in       (req_b),
        .req_ready_out  (req_ready),
        .core_a_out     (core_a),
        .core_b_out     (core_b),
        .core_valid_out (core_valid_o),
        .core_result_in (core_result),
        .core_valid_in  (core_valid_i),
        .resp_valid_out (resp_valid),
        .resp_data_out  (resp_data),
        .busy_out       (busy),
        .err_out        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int npass  = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    endtask

    // Positive-normal single-precision add with truncation: the adder core model
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  e;
        logic [24:0] s;
        int          d;
        if (x[30:0] >= y[30:0]) begin hi = x; lo = y; end
        else begin hi = y; lo = x; end
        e = hi[30:23];
        d = int'(hi[30:23]) - int'(lo[30:23]);
        s = {2'b01, hi[22:0]} + ((d > 24) ? 25'd0 : ({2'b01, lo[22:0]} >> d));
        if (s[24]) begin
            s = s >> 1;
            e = e + 8'd1;
        end
        return {1'b0, e, s[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'b0, 8'(100 + $urandom_range(50)), 23'($urandom)};
    endfunction

    typedef struct { int id; logic [31:0] a; logic [31:0] b; } op_t;
    typedef struct { logic [31:0] a; logic [31:0] b; int cyc; } iss_t;
    typedef struct { int id; logic [31:0] data; int cyc; } rsp_t;
    typedef struct { logic [31:0] res; int due; } pipe_t;

    op_t   mq[$];          // outstanding ops in issue order (reference occupancy)
    iss_t  issue_q[$];
    rsp_t  resp_q[$];
    pipe_t core_pipe[$];
    int    gseq[$];
    int    grants[N];
    int    mlast = N - 1;
    bit    merr = 1'b0;
    bit    mon_en = 1'b0;
    bit [N-1:0] acc = '0;

    bit         auto_en = 1'b0;
    bit         rand_en = 1'b0;
    bit [N-1:0] mask = '0;
    bit         stall = 1'b0;
    bit         stall_rand = 1'b0;
    int         release_one = 0;
    bit         stray = 1'b0;

    // Requesters: hold op until accepted, then optionally present a new one
    initial forever begin
        @(posedge clk);
        #1;
        if (auto_en) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && !acc[i])) begin
                    req_valid[i] = mask[i] && (!rand_en || ($urandom % 2 == 1));
                    req_a[i*DW +: DW] = rnd_fp();
                    req_b[i*DW +: DW] = rnd_fp();
                end
            end
        end
    end

    // Core result side: in-order pipeline with optional stalls and stray pulses
    initial forever begin
        @(posedge clk);
        #1;
        core_valid_i = 1'b0;
        if (stray) begin
            core_valid_i = 1'b1;
            core_result  = 32'hdeadbeef;
            stray        = 1'b0;
        end else if (core_pipe.size() > 0 && core_pipe[0].due <= cyc) begin
            bit go;
            go = !stall || (release_one > 0);
            if (stall_rand && ($urandom % 4 == 0)) go = 1'b0;
            if (go) begin
                if (stall && release_one > 0) release_one--;
                core_valid_i = 1'b1;
                core_result  = core_pipe[0].res;
                void'(core_pipe.pop_front());
            end
        end
    end

    // Monitor and reference model, sampled on the falling edge
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (rst) begin
                chk("rst_ready", 64'(req_ready), 64'(0));
                chk("rst_core_valid", 64'(core_valid_o), 64'(0));
                chk("rst_resp_valid", 64'(resp_valid), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_err", 64'(err), 64'(0));
                mq.delete();
                issue_q.delete();
                resp_q.delete();
                mlast = N - 1;
                merr  = 1'b0;
                acc   = '0;
            end else begin
                int pg;
                logic [N-1:0] exp_ready;
                pg = -1;
                if (mq.size() < MAXO) begin
`ifdef FP_ARB_FIXED_PRIO_EN
                    for (int k = N - 1; k >= 0; k--) if (req_valid[k]) pg = k;
`else
                    for (int k = N; k >= 1; k--) if (req_valid[(mlast + k) % N]) pg = (mlast + k) % N;
`endif
                end
                exp_ready = '0;
                if (pg >= 0) exp_ready[pg] = 1'b1;
                chk("ready", 64'(req_ready), 64'(exp_ready));
                chk("busy", 64'(busy), 64'(mq.size() != 0));
                chk("err", 64'(err), 64'(merr));

                if (core_valid_o) begin
                    if (issue_q.size() == 0) chk("issue_unexpected", 64'(1), 64'(0));
                    else begin
                        iss_t it;
                        it = issue_q.pop_front();
                        chk("issue_cycle", 64'(cyc), 64'(it.cyc));
                        chk("issue_a", 64'(core_a), 64'(it.a));
                        chk("issue_b", 64'(core_b), 64'(it.b));
                    end
                    core_pipe.push_back('{fadd(core_a, core_b), cyc + LAT});
                end else if (issue_q.size() > 0 && issue_q[0].cyc <= cyc) begin
                    chk("issue_missing", 64'(0), 64'(1));
                    void'(issue_q.pop_front());
                end

                if (resp_valid != '0) begin
                    if (resp_q.size() == 0) chk("resp_unexpected", 64'(resp_valid), 64'(0));
                    else begin
                        rsp_t r;
                        logic [N-1:0] oh;
                        r = resp_q.pop_front();
                        oh = '0;
                        oh[r.id] = 1'b1;
                        chk("resp_cycle", 64'(cyc), 64'(r.cyc));
                        chk("resp_id", 64'(resp_valid), 64'(oh));
                        chk("resp_data", 64'(resp_data), 64'(r.data));
                    end
                end else if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
                    chk("resp_missing", 64'(0), 64'(1));
                    void'(resp_q.pop_front());
                end

                if (core_valid_i) begin
                    if (mq.size() > 0) begin
                        op_t o;
                        o = mq.pop_front();
                        resp_q.push_back('{o.id, fadd(o.a, o.b), cyc + 1});
                    end else begin
                        merr = 1'b1;
                    end
                end

                if (pg >= 0) begin
                    mq.push_back('{pg, req_a[pg*DW +: DW], req_b[pg*DW +: DW]});
                    issue_q.push_back('{req_a[pg*DW +: DW], req_b[pg*DW +: DW], cyc + 1});
                    mlast = pg;
                    grants[pg]++;
                    gseq.push_back(pg);
                end
                acc = req_valid & req_ready;
            end
        end
    end

    task automatic drain();
        int t;
        @(negedge clk);
        mask = '0;
        stall = 1'b0;
        stall_rand = 1'b0;
        for (t = 0; t < 600; t++) begin
            @(negedge clk);
            if (req_valid == '0 && mq.size() == 0 && core_pipe.size() == 0 &&
                resp_q.size() == 0 && issue_q.size() == 0) break;
        end
        if (t == 600) chk("drain_timeout", 64'(0), 64'(1));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("reset_now_ready", 64'(req_ready), 64'(0));
        chk("reset_now_core_valid", 64'(core_valid_o), 64'(0));
        chk("reset_now_resp", 64'(resp_valid), 64'(0));
        chk("reset_now_busy", 64'(busy), 64'(0));
        chk("reset_now_err", 64'(err), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int t;
        int tacc;
        @(posedge clk);
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Single request: 1.0 + 2.0 from requester 0
        @(posedge clk);
        #2;
        req_valid = 4'b0001;
        req_a[0 +: DW] = FP_ONE;
        req_b[0 +: DW] = 32'h40000000;
        tacc = -1;
        for (t = 0; t < 20; t++) begin
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) begin tacc = cyc; break; end
        end
        chk("single_accept", 64'(tacc >= 0), 64'(1));
        @(posedge clk);
        #2;
        req_valid = '0;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (resp_valid != '0) break;
        end
        chk("single_latency", 64'(cyc), 64'(tacc + LAT + 2));
        chk("single_id", 64'(resp_valid), 64'(4'b0001));
        chk("single_data", 64'(resp_data), 64'(32'h40400000));
        chk("single_busy_fall", 64'(busy), 64'(0));
        drain();

        // All four continuously valid from a fresh pointer
        pulse_reset();
        @(negedge clk);
        gseq.delete();
        rand_en = 1'b0;
        mask = 4'b1111;
        auto_en = 1'b1;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (gseq.size() >= 8) break;
        end
        mask = '0;
        chk("all4_count", 64'(gseq.size() >= 8), 64'(1));
        for (int k = 0; k < 8 && k < gseq.size(); k++) begin
`ifdef FP_ARB_FIXED_PRIO_EN
            chk("prio_seq", 64'(gseq[k]), 64'(0));
`else
            chk("rr_seq", 64'(gseq[k]), 64'(k % N));
`endif
        end
        drain();

        // Fill the tag FIFO with the core stalled, then release a single result
        @(negedge clk);
        stall = 1'b1;
        mask = 4'b1111;
        for (t = 0; t < 100; t++) begin
            @(negedge clk);
            if (mq.size() == MAXO) break;
        end
        chk("fill_reached", 64'(mq.size()), 64'(MAXO));
        repeat (3) @(negedge clk);
        chk("full_ready", 64'(req_ready), 64'(0));
        chk("full_busy", 64'(busy), 64'(1));
        release_one = 1;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (core_valid_i) break;
        end
        chk("pop_cycle_ready", 64'(req_ready), 64'(0));
        @(negedge clk);
        chk("after_pop_grant", 64'($countones(req_ready)), 64'(1));
        drain();

        // Stray core result with nothing outstanding
        @(negedge clk);
        stray = 1'b1;
        repeat (3) @(negedge clk);
        chk("stray_err", 64'(err), 64'(1));
        rand_en = 1'b1;
        stall_rand = 1'b1;
        mask = 4'b1111;
        repeat (300) @(negedge clk);
        chk("err_sticky", 64'(err), 64'(1));
        drain();

        // Reset with operations in flight; late results must be dropped
        @(negedge clk);
        rand_en = 1'b0;
        mask = 4'b1111;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (mq.size() >= 5) break;
        end
        @(posedge clk);
        #2;
        auto_en = 1'b0;
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("midrst_ready", 64'(req_ready), 64'(0));
        chk("midrst_core_valid", 64'(core_valid_o), 64'(0));
        chk("midrst_resp", 64'(resp_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_err", 64'(err), 64'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        for (t = 0; t < 40; t++) begin
            @(negedge clk);
            if (core_pipe.size() == 0) break;
        end
        repeat (2) @(negedge clk);
        chk("late_result_err", 64'(err), 64'(1));

        // Requesters 1 and 3 held valid
        @(negedge clk);
        for (int k = 0; k < N; k++) grants[k] = 0;
        mask = 4'b1010;
        auto_en = 1'b1;
        repeat (20) @(negedge clk);
        drain();
`ifdef FP_ARB_FIXED_PRIO_EN
        chk("fixed_g3_never", 64'(grants[3]), 64'(0));
        chk("fixed_g1_many", 64'(grants[1] >= 15), 64'(1));
`else
        chk("rr_g3_served", 64'(grants[3] > 0), 64'(1));
        chk("rr_balance", 64'((grants[1] - grants[3] <= 1) && (grants[3] - grants[1] <= 1)), 64'(1));
`endif

        pulse_reset();
        repeat (2) @(negedge clk);
        chk("final_err_clear", 64'(err), 64'(0));

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/fp_op_arbiter.md
Name: fp_op_arbiter

Overview:
- Shares one pipelined floating-point operator (the adder or multiplier IP, AXI-stream style, fixed latency, always-ready result) between NUM_REQ requesters.
- Requesters are the transformation and projection stages that each would otherwise instantiate their own FP core.
- Grants by round-robin, issues one operation per cycle to the core, and tags each operation with a requester ID in an in-order tag FIFO.
- Routes each core result back to the requester that issued it.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- MAX_OUT, 16, maximum outstanding operations; tag FIFO depth (power of 2, at least core latency + 2)
- DATA_W, 32, operand/result width (IEEE-754 single)

Ports:
- clk_in  in  1  clock
- rst_in  in  1  asynchronous, active-high reset
- req_valid_in  in  NUM_REQ  per-requester operation valid
- req_a_in  in  NUM_REQ x DATA_W  operand A per requester
- req_b_in  in  NUM_REQ x DATA_W  operand B per requester
- req_ready_out  out  NUM_REQ  one-hot accept; combinational
- core_a_out  out  DATA_W  to core s_axis_a_tdata
- core_b_out  out  DATA_W  to core s_axis_b_tdata
- core_valid_out  out  1  to core s_axis_a/b_tvalid
- core_result_in  in  DATA_W  core m_axis_result_tdata
- core_valid_in  in  1  core m_axis_result_tvalid (core tready tied 1)
- resp_valid_out  out  NUM_REQ  one-hot result valid
- resp_data_out  out  DATA_W  result, shared by all requesters
- busy_out  out  1  tag FIFO non-empty
- err_out  out  1  sticky: core result arrived with tag FIFO empty

Behaviour:
- Reset (async assert, sync deassert in integration): req_ready_out=0, core_valid_out=0, core_a/b_out=0, resp_valid_out=0, resp_data_out=0, busy_out=0, err_out=0, FIFO empty, rr pointer=NUM_REQ-1 (requester 0 wins first).
- Handshake: a requester holds valid and operands stable until it sees ready. Accept = valid & ready in the same cycle. Valid must not depend on ready.
- Arbitration: candidates are req_valid_in. The search starts at pointer+1 and wraps modulo NUM_REQ. The first valid candidate gets ready, unless the FIFO is full, in which case all ready=0.
- At most one grant per cycle. The pointer updates to the granted index only on accept.
- Full: count==MAX_OUT blocks grants, even if a pop happens the same cycle (no push-on-pop bypass).
- Issue: on accept at cycle T, core_a/b_out are registered with the granted operands and core_valid_out=1 at T+1 for exactly one cycle per accept. The granted ID is pushed to the tag FIFO at T.
- Back-to-back accepts give continuous core_valid_out.
- Return: on core_valid_in at cycle R, pop the FIFO head ID. At R+1, resp_valid_out[ID]=1 and resp_data_out=core_result_in. Both are registered; the pulse lasts one cycle.
- Results return in issue order. Total latency = core latency + 2 cycles.
- Simultaneous push and pop: count unchanged, both take effect.
- Empty: core_valid_in with the FIFO empty drops the result (no resp pulse) and sets err_out until reset.
- Reset mid-operation: FIFO and pointer clear immediately. In-flight core results arriving afterwards fall under the Empty rule. The integrator resets the core with the same rst_in.
- Starvation bound: a continuously valid requester is accepted within NUM_REQ grant opportunities.

Optional Feature:
- Macro FP_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; pointer logic removed.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Decomposition:
- Package fp_arb_pkg: tag type sized by clog2 of the maximum NUM_REQ, FP constants (FP_ZERO=32'h00000000, FP_ONE=32'h3f800000) for benches and clients.
- Sub-module tag_fifo: synchronous FIFO with width = tag width, depth MAX_OUT. Outputs full, empty, count. Same async reset.
- Arbitration and output registers live in fp_op_arbiter.

Test Plan:
- Single request: req0 issues a=3f800000, b=40000000 to the adder model (latency 11) → core_valid_out at T+1; resp_valid_out=0001 and data 40400000 at T+13; busy_out falls the cycle after the pop.
- All 4 requesters hold valid for 8 cycles → grants 0,1,2,3,0,1,2,3; responses in the same order with matching data.
- Fill: core model stalls results, 16 accepts made → ready all 0 with count 16. Release one result → one grant resumes only the cycle after the pop.
- Stray result: pulse core_valid_in with the FIFO empty → no resp_valid_out; err_out=1 and stays 1 until rst_in.
- Reset with 5 in flight: assert rst_in mid-stream → outputs zero immediately. Later core results → dropped, err_out=1.
- FP_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 always valid → requester 1 granted every cycle; requester 3 never granted.
